// File: rtl/mem_init_loader_if.sv
// Stream-in and memory-side bus of mem_init_loader.
// master: the loader (consumes the word stream, drives the memory init path).
// slave : the environment (word source and data memory).
interface mem_init_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] mem_address;
  logic [31:0] mem_datain1;
  logic [31:0] mem_datain2;
  logic [3:0]  mem_wr;
  logic        mem_enable_debug;
  logic [31:0] mem_dataout;

  modport master (
    input  in_valid, in_data, mem_dataout,
    output in_ready, mem_address, mem_datain1, mem_datain2, mem_wr, mem_enable_debug
  );

  modport slave (
    output in_valid, in_data, mem_dataout,
    input  in_ready, mem_address, mem_datain1, mem_datain2, mem_wr, mem_enable_debug
  );
endinterface

// File: rtl/mem_init_loader.sv
// Debug-path memory loader: packs a 32-bit word stream into two-word beats and
// writes them through the memory's dual-slot init path.
// Optional feature macro: MEM_LOADER_VERIFY_EN adds a read-back checksum pass
// that raises error when the memory contents disagree with the loaded words.
module mem_init_loader #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned CNT_W    = 11,
  parameter logic [31:0] PAD_WORD = 32'h0000_0000
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [CNT_W-1:0]   word_count,
  mem_init_loader_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic               error
);

`ifdef MEM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, FIRST, SECOND, WRITE, VREQ, VCHK, FIN} state_e;
`else
  typedef enum logic [2:0] {IDLE, FIRST, SECOND, WRITE, FIN} state_e;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   beat_addr_q, beat_addr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [31:0]         sum_q, sum_d;
  logic                in_ready_q, in_ready_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         d1_q, d1_d;
  logic [31:0]         d2_q, d2_d;
  logic [3:0]          wr_q, wr_d;
  logic                dbg_q, dbg_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                hs_c;

`ifdef MEM_LOADER_VERIFY_EN
  logic [ADDR_W-1:0]   vaddr_q, vaddr_d;
  logic [CNT_W-1:0]    vrem_q, vrem_d;
  logic [31:0]         rsum_q, rsum_d;
`else
  logic                unused_c;
  assign unused_c = ^{bus.mem_dataout, sum_q};
`endif

  assign hs_c = bus.in_valid && in_ready_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    beat_addr_d = beat_addr_q;
    rem_d       = rem_q;
    sum_d       = sum_q;
    addr_d      = addr_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    error_d     = error_q;
`ifdef MEM_LOADER_VERIFY_EN
    vaddr_d     = vaddr_q;
    vrem_d      = vrem_q;
    rsum_d      = rsum_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (base_addr[2:0] != 3'b000) begin
            error_d = 1'b1;
            state_d = FIN;
          end else if (word_count == '0) begin
            state_d = FIN;
          end else begin
            beat_addr_d = base_addr;
            rem_d       = word_count;
            sum_d       = '0;
`ifdef MEM_LOADER_VERIFY_EN
            vaddr_d     = base_addr;
            vrem_d      = word_count;
            rsum_d      = '0;
`endif
            state_d     = FIRST;
          end
        end
      end
      FIRST: begin
        if (hs_c) begin
          d1_d  = bus.in_data;
          sum_d = sum_q + bus.in_data;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            d2_d    = PAD_WORD;
            state_d = WRITE;
          end else begin
            state_d = SECOND;
          end
        end
      end
      SECOND: begin
        if (hs_c) begin
          d2_d    = bus.in_data;
          sum_d   = sum_q + bus.in_data;
          rem_d   = rem_q - CNT_W'(1);
          state_d = WRITE;
        end
      end
      WRITE: begin
        beat_addr_d = beat_addr_q + ADDR_W'(8);
        if (rem_q != '0) begin
          state_d = FIRST;
        end else begin
`ifdef MEM_LOADER_VERIFY_EN
          state_d = VREQ;
`else
          state_d = FIN;
`endif
        end
      end
`ifdef MEM_LOADER_VERIFY_EN
      VREQ: begin
        state_d = VCHK;
      end
      VCHK: begin
        rsum_d = rsum_q + bus.mem_dataout;
        vrem_d = vrem_q - CNT_W'(1);
        if (vrem_q == CNT_W'(1)) begin
          if (rsum_d != sum_q) error_d = 1'b1;
          state_d = FIN;
        end else begin
          state_d = VREQ;
        end
      end
`endif
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    in_ready_d = (state_d == FIRST) || (state_d == SECOND);
    busy_d     = (state_d != IDLE) && (state_d != FIN);
    done_d     = (state_d == FIN);
    wr_d       = 4'b0000;
    dbg_d      = 1'b0;
    if (state_d == WRITE) begin
      wr_d   = 4'b1111;
      dbg_d  = 1'b1;
      addr_d = 32'(beat_addr_q);
    end
`ifdef MEM_LOADER_VERIFY_EN
    if (state_d == VREQ) begin
      addr_d  = 32'(vaddr_q);
      vaddr_d = vaddr_q + ADDR_W'(4);
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      beat_addr_q <= '0;
      rem_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b0;
      addr_q      <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      wr_q        <= '0;
      dbg_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
      vaddr_q     <= '0;
      vrem_q      <= '0;
      rsum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_addr_q <= beat_addr_d;
      rem_q       <= rem_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      addr_q      <= addr_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      wr_q        <= wr_d;
      dbg_q       <= dbg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef MEM_LOADER_VERIFY_EN
      vaddr_q     <= vaddr_d;
      vrem_q      <= vrem_d;
      rsum_q      <= rsum_d;
`endif
    end
  end

  assign bus.in_ready         = in_ready_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_datain1      = d1_q;
  assign bus.mem_datain2      = d2_q;
  assign bus.mem_wr           = wr_q;
  assign bus.mem_enable_debug = dbg_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign error                = error_q;

endmodule

// File: tb/tb_mem_init_loader.sv
// Bench for mem_init_loader: table of loads plus randomized loads, each checked
// against a word-list reference model (expected beats, memory image, timing).
module tb_mem_init_loader;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned CNT_W     = 11;
  localparam logic [31:0] PAD       = 32'h0000_0000;
  localparam int          MEM_WORDS = 1 << (ADDR_W - 2);
  localparam int          ADDR_SPAN = 1 << ADDR_W;
`ifdef MEM_LOADER_VERIFY_EN
  localparam int          VERIFY    = 1;
`else
  localparam int          VERIFY    = 0;
`endif

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              busy, done, error;

  mem_init_loader_if bus();

  mem_init_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .PAD_WORD(PAD)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .bus(bus.master), .busy(busy), .done(done), .error(error)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Data memory model: dual-slot init write, synchronous read, optional corruption.
  logic [31:0] mem [MEM_WORDS];
  bit          corrupt_en = 1'b0;
  int          corrupt_idx = 0;
  int          wa, ra;
  always @(posedge Clk) begin
    wa = int'(bus.mem_address[ADDR_W-1:2]);
    if (bus.mem_enable_debug && bus.mem_wr == 4'hF) begin
      mem[wa] <= bus.mem_datain1;
      mem[(wa + 1) % MEM_WORDS] <= bus.mem_datain2;
    end
    ra = wa;
    bus.mem_dataout <= (corrupt_en && ra == corrupt_idx) ? 32'h0 : mem[ra];
  end

  // Monitor: every cycle with write activity is one observed beat.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  wr;
    logic        dbg;
  } beat_t;
  beat_t obs_q[$];
  always @(negedge Clk) begin
    if (bus.mem_wr != 4'h0 || bus.mem_enable_debug)
      obs_q.push_back('{a: bus.mem_address, d1: bus.mem_datain1, d2: bus.mem_datain2,
                        wr: bus.mem_wr, dbg: bus.mem_enable_debug});
  end

  task automatic check_all_zero(input string p);
    chk({p, "_in_ready"}, 32'(bus.in_ready), 32'h0);
    chk({p, "_mem_address"}, bus.mem_address, 32'h0);
    chk({p, "_mem_datain1"}, bus.mem_datain1, 32'h0);
    chk({p, "_mem_datain2"}, bus.mem_datain2, 32'h0);
    chk({p, "_mem_wr"}, 32'(bus.mem_wr), 32'h0);
    chk({p, "_mem_enable_debug"}, 32'(bus.mem_enable_debug), 32'h0);
    chk({p, "_busy"}, 32'(busy), 32'h0);
    chk({p, "_done"}, 32'(done), 32'h0);
    chk({p, "_error"}, 32'(error), 32'h0);
  endtask

  // One complete load: mode 0 random words, 1 words 1..n, 2 constant 0xA5A5A5A5.
  task automatic run_load(input string nm, input logic [ADDR_W-1:0] b, input int n,
                          input int mode, input int gap, input bit held, input bit exp_err);
    logic [31:0] w[$];
    beat_t       exp_q[$];
    bit          mis, got_done;
    int          idx, junk, t_start, t_last, t_done, nb, base_w, exp_lat;
    logic [31:0] ev;

    for (int i = 0; i < n; i++)
      w.push_back(mode == 1 ? 32'(i + 1) : (mode == 2 ? 32'hA5A5_A5A5 : $urandom));
    mis = (b[2:0] != 3'b000);
    nb  = (mis || n == 0) ? 0 : (n + 1) / 2;
    for (int k = 0; k < nb; k++)
      exp_q.push_back('{a: 32'((int'(b) + 8 * k) % ADDR_SPAN), d1: w[2 * k],
                        d2: (2 * k + 1 < n) ? w[2 * k + 1] : PAD, wr: 4'hF, dbg: 1'b1});

    obs_q.delete();
    @(negedge Clk);
    start = 1'b1; base_addr = b; word_count = CNT_W'(n); t_start = cyc;
    @(negedge Clk);
    start = 1'b0;
    if (nb > 0) chk({nm, "_busy_after_start"}, 32'(busy), 32'h1);

    idx = 0; junk = 0; got_done = 1'b0; t_last = t_start; t_done = 0;
    for (int c = 0; c < 4000 && !got_done; c++) begin
      if (done) begin
        got_done = 1'b1;
        t_done   = cyc;
      end else begin
        if (idx < n) begin
          bus.in_valid = held || ($urandom_range(99) >= gap);
          bus.in_data  = w[idx];
        end else begin
          bus.in_valid = 1'b1;
          bus.in_data  = $urandom;
        end
        if (bus.in_valid && bus.in_ready) begin
          if (idx < n) begin idx++; t_last = cyc; end
          else junk++;
        end
        @(negedge Clk);
      end
    end
    bus.in_valid = 1'b0;

    chk({nm, "_done_seen"}, 32'(got_done), 32'h1);
    chk({nm, "_error"}, 32'(error), 32'(exp_err));
    chk({nm, "_beats"}, 32'(obs_q.size()), 32'(nb));
    chk({nm, "_extra_accepts"}, 32'(junk), 32'h0);
    if (nb == 0) begin
      chk({nm, "_done_latency_from_start"}, 32'(t_done - t_start), 32'h1);
    end else begin
      exp_lat = 2 + VERIFY * 2 * n;
      chk({nm, "_done_latency"}, 32'(t_done - t_last), 32'(exp_lat));
      if (held)
        chk({nm, "_throughput"}, 32'(t_done - t_start),
            32'(1 + 3 * (n / 2) + 2 * (n % 2) + VERIFY * 2 * n));
      for (int k = 0; k < nb && k < obs_q.size(); k++) begin
        chk($sformatf("%s_beat%0d_addr", nm, k), obs_q[k].a, exp_q[k].a);
        chk($sformatf("%s_beat%0d_d1", nm, k), obs_q[k].d1, exp_q[k].d1);
        chk($sformatf("%s_beat%0d_d2", nm, k), obs_q[k].d2, exp_q[k].d2);
        chk($sformatf("%s_beat%0d_wr", nm, k), {27'h0, obs_q[k].wr, obs_q[k].dbg}, 32'h1F);
      end
      base_w = int'(b) / 4;
      for (int i = 0; i < n + (n % 2); i++) begin
        ev = (i < n) ? w[i] : PAD;
        chk($sformatf("%s_mem%0d", nm, i), mem[(base_w + i) % MEM_WORDS], ev);
      end
    end
    @(negedge Clk);
    chk({nm, "_done_pulse_end"}, 32'(done), 32'h0);
    chk({nm, "_busy_idle"}, 32'(busy), 32'h0);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    int                n;
    int                mode;
    int                gap;
    bit                held;
    bit                exp_err;
  } vec_t;
  vec_t vecs[10];

  initial begin
    vecs[0] = '{12'h000, 4, 1, 0, 1'b1, 1'b0};
    vecs[1] = '{12'h010, 3, 0, 0, 1'b1, 1'b0};
    vecs[2] = '{12'hFF8, 4, 0, 0, 1'b1, 1'b0};
    vecs[3] = '{12'h004, 2, 0, 0, 1'b1, 1'b1};
    vecs[4] = '{12'h000, 0, 0, 0, 1'b1, 1'b0};
    vecs[5] = '{12'h100, 1, 0, 30, 1'b0, 1'b0};
    vecs[6] = '{12'h208, 7, 0, 40, 1'b0, 1'b0};
    vecs[7] = '{12'hFF0, 6, 0, 50, 1'b0, 1'b0};
    vecs[8] = '{12'h002, 5, 0, 0, 1'b1, 1'b1};
    vecs[9] = '{12'h7F8, 5, 0, 0, 1'b1, 1'b0};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    // Asynchronous reset while waiting for the second word of a beat.
    @(negedge Clk);
    start = 1'b1; base_addr = 12'h040; word_count = CNT_W'(4);
    @(negedge Clk);
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'hDEAD_BEEF;
    @(negedge Clk);
    bus.in_valid = 1'b0;
    chk("mid_second_d1", bus.mem_datain1, 32'hDEAD_BEEF);
    chk("mid_second_busy", 32'(busy), 32'h1);
    chk("mid_second_ready", 32'(bus.in_ready), 32'h1);
    #2 Reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_load($sformatf("vec%0d", i), vecs[i].base, vecs[i].n, vecs[i].mode,
               vecs[i].gap, vecs[i].held, vecs[i].exp_err);

    for (int r = 0; r < 8; r++)
      run_load($sformatf("rand%0d", r), {9'($urandom_range(511)), 3'b000},
               int'($urandom_range(1, 24)), 0, int'($urandom_range(60)),
               r[0], 1'b0);

`ifdef MEM_LOADER_VERIFY_EN
    corrupt_en  = 1'b1;
    corrupt_idx = (12'h300 >> 2) + 1;
    run_load("verify_corrupt", 12'h300, 2, 2, 0, 1'b1, 1'b1);
    corrupt_en  = 1'b0;
    run_load("verify_clean", 12'h300, 2, 2, 0, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
